// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with full/empty, programmable almost-full and
// almost-empty flags, an occupancy count, and optional sticky error flags.
// Build option: define SYNC_FIFO_ERR_EN to build the sticky overflow/underflow
// flags; otherwise both outputs are tied low and no error logic exists.
module sync_fifo #(
  parameter  int DATA_W   = 8,
  parameter  int DEPTH    = 16,
  parameter  int AF_LEVEL = DEPTH - 2,
  parameter  int AE_LEVEL = 2,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] AF_LVL = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AE_LVL = PTR_W'(AE_LEVEL);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  count_q,  count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              full_s;
  logic              empty_s;
  logic              wr_acc;
  logic              rd_acc;

  assign wr_addr = wr_ptr_q[ADDR_W-1:0];
  assign rd_addr = rd_ptr_q[ADDR_W-1:0];

  // Flags come straight from the registered pointers; the wrap bit tells a
  // full FIFO apart from an empty one when the low address bits coincide.
  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_addr == rd_addr) && (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

  assign wr_acc = wr_en && !full_s;
  assign rd_acc = rd_en && !empty_s;

  // Next-state for pointers, occupancy and read data.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    if (rd_acc) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      rd_data_d = mem_q[rd_addr];
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + PTR_W'(1);
      2'b01:   count_d = count_q - PTR_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register; cleared asynchronously so stored words are
  // logically discarded the moment reset is applied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage array: written only on an accepted write, never reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags: set on any request that the FIFO had to refuse.
  always_comb begin
    overflow_d  = overflow_q  | (wr_en && full_s);
    underflow_d = underflow_q | (rd_en && empty_s);
  end

  // Error flag register; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign rd_data      = rd_data_q;
  assign count        = count_q;
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (count_q >= AF_LVL);
  assign almost_empty = (count_q <= AE_LVL);

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: directed corner cases plus randomized traffic, checked
// against a queue-based reference model of the FIFO's occupancy and data.
module tb_sync_fifo;

  localparam int DATA_W   = 8;
  localparam int DEPTH    = 16;
  localparam int AF_LEVEL = DEPTH - 2;
  localparam int AE_LEVEL = 2;
  localparam int ADDR_W   = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model
  logic [DATA_W-1:0] mq [$];
  logic [DATA_W-1:0] m_rd;
`ifdef SYNC_FIFO_ERR_EN
  logic m_ovf;
  logic m_unf;
`endif

  sync_fifo #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_rd = '0;
`ifdef SYNC_FIFO_ERR_EN
    m_ovf = 1'b0;
    m_unf = 1'b0;
`endif
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ":count"}, 32'(count), 32'(mq.size()));
    chk({ctx, ":empty"}, 32'(empty), 32'(mq.size() == 0));
    chk({ctx, ":full"}, 32'(full), 32'(mq.size() == DEPTH));
    chk({ctx, ":almost_full"}, 32'(almost_full), 32'(mq.size() >= AF_LEVEL));
    chk({ctx, ":almost_empty"}, 32'(almost_empty), 32'(mq.size() <= AE_LEVEL));
    chk({ctx, ":rd_data"}, 32'(rd_data), 32'(m_rd));
`ifdef SYNC_FIFO_ERR_EN
    chk({ctx, ":overflow"}, 32'(overflow), 32'(m_ovf));
    chk({ctx, ":underflow"}, 32'(underflow), 32'(m_unf));
`else
    chk({ctx, ":overflow"}, 32'(overflow), 32'd0);
    chk({ctx, ":underflow"}, 32'(underflow), 32'd0);
`endif
  endtask

  // One clock cycle: drive at the falling edge, advance the model at the
  // rising edge, compare 1 time unit later.
  task automatic step(input string ctx, input logic w, input logic [DATA_W-1:0] d,
                      input logic r);
    bit was_full, was_empty;
    @(negedge clk);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    @(posedge clk);
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
`ifdef SYNC_FIFO_ERR_EN
    if (w && was_full)  m_ovf = 1'b1;
    if (r && was_empty) m_unf = 1'b1;
`endif
    if (r && !was_empty) m_rd = mq.pop_front();
    if (w && !was_full)  mq.push_back(d);
    #1;
    check_all(ctx);
  endtask

  initial begin
    int bias_w, bias_r;
    bit seen_aa;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;
    model_reset();

    // power-on reset
    repeat (2) @(posedge clk);
    #1;
    check_all("por");
    @(negedge clk);
    rst_n = 1'b1;

    // fill 0x00..0x0F, flags track occupancy
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 8'(i), 1'b0);

    // write while full is dropped
    step("ovf", 1'b1, 8'hAA, 1'b0);
    step("ovf_hold", 1'b0, 8'h00, 1'b0);

    // drain, data in order, no 0xAA
    seen_aa = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      step("drain", 1'b0, 8'h00, 1'b1);
      if (rd_data == 8'hAA) seen_aa = 1'b1;
    end
    chk("no_aa", 32'(seen_aa), 32'd0);

    // read while empty ignored
    step("unf", 1'b0, 8'h00, 1'b1);
    step("unf2", 1'b0, 8'h00, 1'b1);

    // simultaneous read/write while empty: write only
    step("rw_empty", 1'b1, 8'h55, 1'b1);
    step("rd_55", 1'b0, 8'h00, 1'b1);
    chk("rd_55_val", 32'(rd_data), 32'h55);

    // steady state at count 8, pointers wrap
    for (int i = 0; i < 8; i++) step("to8", 1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) step("rw8", 1'b1, 8'($urandom), 1'b1);

    // simultaneous read/write while full: read only
    for (int i = 0; i < 8; i++) step("to16", 1'b1, 8'($urandom), 1'b0);
    step("rw_full", 1'b1, 8'hAA, 1'b1);
    chk("rw_full_cnt", 32'(count), 32'd15);

    // randomized traffic in phases of differing bias
    for (int p = 0; p < 4; p++) begin
      case (p)
        0: begin bias_w = 80; bias_r = 30; end
        1: begin bias_w = 30; bias_r = 80; end
        2: begin bias_w = 60; bias_r = 60; end
        default: begin bias_w = 95; bias_r = 90; end
      endcase
      for (int i = 0; i < 100; i++)
        step("rand", 1'($urandom_range(0, 99) < bias_w), 8'($urandom),
             1'($urandom_range(0, 99) < bias_r));
    end

    // mid-stream asynchronous reset
    for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 8'($urandom), 1'b0);
    step("pre_rst_rd", 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = 8'h99;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("in_rst");
    @(negedge clk);
    wr_en = 1'b0;
    rst_n = 1'b1;

    step("post_wr", 1'b1, 8'h3C, 1'b0);
    step("post_wr2", 1'b1, 8'hC3, 1'b0);
    step("post_rd", 1'b0, 8'h00, 1'b1);
    chk("post_rd_val", 32'(rd_data), 32'h3C);
    step("post_rd2", 1'b0, 8'h00, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
